kf8259_in_service_param: RTL

KF8259_IN_SERVICE_PARAM -- requirements
Module: kf8259_in_service_param

---
 rtl/kf8259_in_service_param.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/kf8259_in_service_param.sv
// ---------------------------------------------------------------------------
// kf8259_in_service_param
//
// In-service register (ISR) block of an 8259-style interrupt controller with
// a configurable number of levels. It tracks acknowledged interrupts and
// clears them on specific, non-specific or automatic end-of-interrupt. It
// maintains the rotating-priority pointer and reports the highest-priority
// level currently in service.
//
// Ports
//   clock                    system clock, all state on its rising edge
//   reset                    synchronous active-high reset
//   start_in_service         acknowledge strobe, ORs 'interrupt' into ISR
//   interrupt[LEVELS]        acknowledged level(s), nominally one-hot
//   eoi_cmd                  end-of-interrupt command strobe
//   eoi_specific             1 = clear eoi_level, 0 = clear highest level
//   eoi_level[IDX_W]         level index for a specific EOI
//   eoi_rotate               load the cleared level as lowest priority
//   set_priority             load priority_level as lowest priority
//   priority_level[IDX_W]    new lowest-priority level index
//   auto_eoi_mode            acknowledged levels clear themselves next cycle
//   auto_rotate_mode         rotate priority on an automatic EOI
//   special_mask_mode        masked levels do not take part in resolution
//   imr[LEVELS]              interrupt mask register
//   in_service_register      registered ISR
//   highest_level_in_service registered one-hot highest level in service
//   priority_rotate          registered index of the lowest-priority level
//   eoi_miss                 one-cycle pulse: an EOI cleared nothing
// ---------------------------------------------------------------------------
module kf8259_in_service_param #(
  parameter int LEVELS = 8,
  parameter int IDX_W  = $clog2(LEVELS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_in_service,
  input  logic [LEVELS-1:0] interrupt,
  input  logic              eoi_cmd,
  input  logic              eoi_specific,
  input  logic [IDX_W-1:0]  eoi_level,
  input  logic              eoi_rotate,
  input  logic              set_priority,
  input  logic [IDX_W-1:0]  priority_level,
  input  logic              auto_eoi_mode,
  input  logic              auto_rotate_mode,
  input  logic              special_mask_mode,
  input  logic [LEVELS-1:0] imr,
  output logic [LEVELS-1:0] in_service_register,
  output logic [LEVELS-1:0] highest_level_in_service,
  output logic [IDX_W-1:0]  priority_rotate,
  output logic              eoi_miss
);

  // Registered state
  logic [LEVELS-1:0] r_isr;
  logic [LEVELS-1:0] r_highest;
  logic [LEVELS-1:0] r_pending;   // levels awaiting their automatic EOI
  logic [IDX_W-1:0]  r_rotate;
  logic              r_eoi_miss;

  // Command decode
  logic              w_level_ok;
  logic              w_prio_ok;
  logic [IDX_W-1:0]  w_highest_idx;
  logic [LEVELS-1:0] w_pend_low;
  logic [IDX_W-1:0]  w_pend_idx;
  logic [LEVELS-1:0] w_eoi_clear;
  logic              w_eoi_hit;
  logic [IDX_W-1:0]  w_eoi_idx;

  // Next-state values
  logic [LEVELS-1:0] w_clear_vec;
  logic [LEVELS-1:0] w_set_vec;
  logic [LEVELS-1:0] w_isr_next;
  logic [LEVELS-1:0] w_pending_next;
  logic [IDX_W-1:0]  w_rot_next;
  logic              w_miss_next;

  // Highest-level resolution
  logic [LEVELS-1:0] w_masked;
  logic [LEVELS-1:0] w_upper_mask;
  logic [LEVELS-1:0] w_upper_part;
  logic [LEVELS-1:0] w_pick;
  logic [LEVELS-1:0] w_highest_next;

  // Index widths can express values >= LEVELS when LEVELS is not a power
  // of two; such indices must be treated as out of range.
  assign w_level_ok = int'(eoi_level) < LEVELS;
  assign w_prio_ok  = int'(priority_level) < LEVELS;

  // Lowest-numbered pending level, isolated as x & -x.
  assign w_pend_low = r_pending & (~r_pending + LEVELS'(1));

  // One-hot to index encoders for the registered highest level and for the
  // lowest pending level.
  always_comb begin
    w_highest_idx = '0;
    w_pend_idx    = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (r_highest[i]) begin
        w_highest_idx = w_highest_idx | IDX_W'(i);
      end
      if (w_pend_low[i]) begin
        w_pend_idx = w_pend_idx | IDX_W'(i);
      end
    end
  end

  // EOI command: which bit(s) it clears and whether it hit anything.
  always_comb begin
    w_eoi_clear = '0;
    w_eoi_hit   = 1'b0;
    w_eoi_idx   = '0;
    if (eoi_cmd) begin
      if (eoi_specific) begin
        if (w_level_ok && r_isr[eoi_level]) begin
          w_eoi_clear[eoi_level] = 1'b1;
          w_eoi_hit              = 1'b1;
          w_eoi_idx              = eoi_level;
        end
      end else if (|r_highest) begin
        w_eoi_clear = r_highest;
        w_eoi_hit   = 1'b1;
        w_eoi_idx   = w_highest_idx;
      end
    end
  end

  assign w_miss_next = eoi_cmd & ~w_eoi_hit;

  // The automatic EOI of last cycle's acknowledge merges with any command
  // EOI; a fresh acknowledge of the same bit still wins.
  assign w_clear_vec    = w_eoi_clear | r_pending;
  assign w_set_vec      = start_in_service ? interrupt : '0;
  assign w_isr_next     = (r_isr & ~w_clear_vec) | w_set_vec;
  assign w_pending_next = (start_in_service && auto_eoi_mode) ? interrupt : '0;

  // Rotation pointer update, highest-precedence source first.
  always_comb begin
    w_rot_next = r_rotate;
    if (set_priority && w_prio_ok) begin
      w_rot_next = priority_level;
    end else if (eoi_cmd && eoi_rotate && w_eoi_hit) begin
      w_rot_next = w_eoi_idx;
    end else if ((|r_pending) && auto_rotate_mode) begin
      w_rot_next = w_pend_idx;
    end
  end

  // Priority runs from level rot+1 upward and wraps to level 0. Levels above
  // the pointer are therefore searched first; if none is active the search
  // wraps and takes the lowest-numbered active level overall. This needs no
  // modulo arithmetic, so any LEVELS value works.
  assign w_masked = w_isr_next & (special_mask_mode ? ~imr : {LEVELS{1'b1}});

  for (genvar gi = 0; gi < LEVELS; gi++) begin : g_upper
    assign w_upper_mask[gi] = (gi > int'(w_rot_next));
  end

  assign w_upper_part   = w_masked & w_upper_mask;
  assign w_pick         = (|w_upper_part) ? w_upper_part : w_masked;
  assign w_highest_next = w_pick & (~w_pick + LEVELS'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_isr      <= '0;
      r_highest  <= '0;
      r_pending  <= '0;
      r_rotate   <= IDX_W'(LEVELS - 1);
      r_eoi_miss <= 1'b0;
    end else begin
      r_isr      <= w_isr_next;
      r_highest  <= w_highest_next;
      r_pending  <= w_pending_next;
      r_rotate   <= w_rot_next;
      r_eoi_miss <= w_miss_next;
    end
  end

  assign in_service_register      = r_isr;
  assign highest_level_in_service = r_highest;
  assign priority_rotate          = r_rotate;
  assign eoi_miss                 = r_eoi_miss;

endmodule
